fg_prog_sequencer: RTL and testbench



---
 rtl/fg_prog_pkg.sv | 26 ++
 rtl/fg_prog_timer.sv | 35 +++
 rtl/fg_prog_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_prog_pkg.sv
// rtl/fg_prog_pkg.sv - shared types and encodings for the floating-gate programming sequencer
package fg_prog_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_MEAS,
        S_DONE
    } state_e;

    localparam logic [1:0] MODE_INJ  = 2'b00;
    localparam logic [1:0] MODE_TUN  = 2'b01;
    localparam logic [1:0] MODE_READ = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_ABORT  = 2'b01;
    localparam logic [1:0] ST_BADCMD = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fg_prog_timer.sv
// rtl/fg_prog_timer.sv - loadable down-counter timing the settle, gap and pulse phases
module fg_prog_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load phase length minus one; count down and rest at zero, which marks the last cycle of the phase
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// rtl/fg_prog_sequencer.sv - settle/pulse/gap/measure sequencer steering one floating-gate island
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int N_ISLANDS = 2,
    parameter int ROW_BITS  = 6,
    parameter int COL_BITS  = 6,
    parameter int SETTLE    = 8,
    parameter int PW_BITS   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(N_ISLANDS)-1:0]  cmd_island,
    input  logic [ROW_BITS-1:0]           cmd_row,
    input  logic [COL_BITS-1:0]           cmd_col,
    input  logic [1:0]                    cmd_mode,
    input  logic [7:0]                    cmd_pulses,
    input  logic [PW_BITS-1:0]            cmd_width,
    input  logic                          abort,
    output logic [N_ISLANDS-1:0]          island_sel,
    output logic [ROW_BITS-1:0]           row_addr,
    output logic [COL_BITS-1:0]           col_addr,
    output logic                          dec_en,
    output logic                          drain_sel,
    output logic                          prog_en,
    output logic                          tun_en,
    output logic                          meas_req,
    input  logic                          meas_ack,
    output logic                          rsp_valid,
    output logic [1:0]                    rsp_status
);

    localparam int IW = $clog2(N_ISLANDS);
    localparam int TW = max_int(PW_BITS, $clog2(SETTLE + 1));
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         isl_q, isl_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [1:0]            mode_q, mode_d;
    logic [PW_BITS-1:0]    wid_q, wid_d;
    logic [PW_BITS-1:0]    wid_m1;
    logic [7:0]            pulses_q, pulses_d;
    logic [1:0]            status_q, status_d;
    logic                  tmr_load, tmr_done;
    logic [TW-1:0]         tmr_val;

    logic                  cmd_ready_d, dec_en_d, drain_sel_d, prog_en_d, tun_en_d;
    logic                  meas_req_d, rsp_valid_d, active, steer;
    logic [N_ISLANDS-1:0]  island_sel_d;
    logic [ROW_BITS-1:0]   row_addr_d;
    logic [COL_BITS-1:0]   col_addr_d;
    logic [1:0]            rsp_status_d;

    // A zero width still produces a one-cycle pulse
    assign wid_m1 = (wid_q == '0) ? '0 : wid_q - PW_BITS'(1);

    fg_prog_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state logic: command latch, phase sequencing, pulse counting; abort overrides everything in flight
    always_comb begin
        state_d  = state_q;
        isl_d    = isl_q;
        row_d    = row_q;
        col_d    = col_q;
        mode_d   = mode_q;
        wid_d    = wid_q;
        pulses_d = pulses_q;
        status_d = status_q;
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    isl_d    = cmd_island;
                    row_d    = cmd_row;
                    col_d    = cmd_col;
                    mode_d   = cmd_mode;
                    wid_d    = cmd_width;
                    pulses_d = cmd_pulses;
                    if (int'(cmd_island) >= N_ISLANDS || cmd_mode == MODE_RSVD) begin
                        state_d  = S_DONE;
                        status_d = ST_BADCMD;
                    end else begin
                        state_d  = S_SETUP;
                        status_d = ST_OK;
                        tmr_load = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (tmr_done) begin
                    if (mode_q != MODE_READ && pulses_q != 8'd0) begin
                        state_d  = S_PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(wid_m1);
                    end else begin
                        state_d = S_MEAS;
                    end
                end
            end
            S_PULSE: begin
                if (tmr_done) begin
                    pulses_d = pulses_q - 8'd1;
                    state_d  = S_GAP;
                    tmr_load = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_done) begin
                    if (pulses_q != 8'd0) begin
                        state_d  = S_PULSE;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(wid_m1);
                    end else begin
                        state_d = S_MEAS;
                    end
                end
            end
            S_MEAS: begin
                if (meas_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_DONE;
            status_d = ST_ABORT;
            tmr_load = 1'b0;
        end
    end

    // Output decode from the next state so every output is a flop that tracks the state register
    always_comb begin
        active       = (state_d inside {S_SETUP, S_PULSE, S_GAP, S_MEAS});
        steer        = (state_d inside {S_SETUP, S_PULSE, S_GAP});
        cmd_ready_d  = (state_d == S_IDLE);
        island_sel_d = '0;
        for (int i = 0; i < N_ISLANDS; i++) begin
            island_sel_d[i] = active && (int'(isl_d) == i);
        end
        row_addr_d   = active ? row_d : '0;
        col_addr_d   = active ? col_d : '0;
        dec_en_d     = active;
        drain_sel_d  = steer && (mode_d != MODE_READ);
        prog_en_d    = (state_d == S_PULSE) && (mode_d == MODE_INJ);
        tun_en_d     = (state_d == S_PULSE) && (mode_d == MODE_TUN);
        meas_req_d   = (state_d == S_MEAS);
        rsp_valid_d  = (state_d == S_DONE);
        rsp_status_d = rsp_valid_d ? status_d : '0;
    end

    // State, command latch and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            isl_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mode_q     <= '0;
            wid_q      <= '0;
            pulses_q   <= '0;
            status_q   <= '0;
            cmd_ready  <= 1'b1;
            island_sel <= '0;
            row_addr   <= '0;
            col_addr   <= '0;
            dec_en     <= 1'b0;
            drain_sel  <= 1'b0;
            prog_en    <= 1'b0;
            tun_en     <= 1'b0;
            meas_req   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
        end else begin
            state_q    <= state_d;
            isl_q      <= isl_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mode_q     <= mode_d;
            wid_q      <= wid_d;
            pulses_q   <= pulses_d;
            status_q   <= status_d;
            cmd_ready  <= cmd_ready_d;
            island_sel <= island_sel_d;
            row_addr   <= row_addr_d;
            col_addr   <= col_addr_d;
            dec_en     <= dec_en_d;
            drain_sel  <= drain_sel_d;
            prog_en    <= prog_en_d;
            tun_en     <= tun_en_d;
            meas_req   <= meas_req_d;
            rsp_valid  <= rsp_valid_d;
            rsp_status <= rsp_status_d;
        end
    end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// tb/tb_fg_prog_sequencer.sv - directed self-checking bench for fg_prog_sequencer
module tb_fg_prog_sequencer;

    localparam int N_ISL = 3;
    localparam int RB    = 6;
    localparam int CB    = 6;
    localparam int STL   = 8;
    localparam int PWB   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_island = '0;
    logic [RB-1:0]     cmd_row = '0;
    logic [CB-1:0]     cmd_col = '0;
    logic [1:0]        cmd_mode = '0;
    logic [7:0]        cmd_pulses = '0;
    logic [PWB-1:0]    cmd_width = '0;
    logic              abort = 1'b0;
    logic [N_ISL-1:0]  island_sel;
    logic [RB-1:0]     row_addr;
    logic [CB-1:0]     col_addr;
    logic              dec_en, drain_sel, prog_en, tun_en, meas_req;
    logic              meas_ack = 1'b0;
    logic              rsp_valid;
    logic [1:0]        rsp_status;

    int checks = 0;
    int errors = 0;

    int rsp_cyc, rsp_stat, meas_cyc, n_rises, prog_cyc, tun_cyc;
    int inv_err, ready_err, drain_in_meas, any_en;
    int rise_at [8];
    logic [N_ISL-1:0] isl_seen;
    logic [RB-1:0]    row_seen;
    logic [CB-1:0]    col_seen;
    logic             drain_seen;

    always #5 clk = ~clk;

    fg_prog_sequencer #(
        .N_ISLANDS (N_ISL),
        .ROW_BITS  (RB),
        .COL_BITS  (CB),
        .SETTLE    (STL),
        .PW_BITS   (PWB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_island (cmd_island),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_mode   (cmd_mode),
        .cmd_pulses (cmd_pulses),
        .cmd_width  (cmd_width),
        .abort      (abort),
        .island_sel (island_sel),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .dec_en     (dec_en),
        .drain_sel  (drain_sel),
        .prog_en    (prog_en),
        .tun_en     (tun_en),
        .meas_req   (meas_req),
        .meas_ack   (meas_ack),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, island_sel, row_addr, col_addr, dec_en, drain_sel,
                prog_en, tun_en, meas_req, rsp_valid, rsp_status};
    endfunction

    // Offers one command in the current (idle) cycle and observes it until rsp_valid or rst_at.
    // Returns positioned at the rsp_valid cycle, or at the cycle after reset was applied.
    task automatic run_cmd(input logic [1:0] isl, input logic [RB-1:0] row, input logic [CB-1:0] col,
                           input logic [1:0] mode, input logic [7:0] pulses, input logic [PWB-1:0] width,
                           input int ack_delay, input int abort_at, input int rst_at);
        logic prev;
        logic pen;
        cmd_valid = 1'b1; cmd_island = isl; cmd_row = row; cmd_col = col;
        cmd_mode = mode; cmd_pulses = pulses; cmd_width = width;
        step();
        cmd_valid = 1'b0;
        rsp_cyc = -1; rsp_stat = -1; meas_cyc = -1; n_rises = 0; prog_cyc = 0; tun_cyc = 0;
        inv_err = 0; ready_err = 0; drain_in_meas = 0; any_en = 0; prev = 1'b0;
        isl_seen = island_sel; row_seen = row_addr; col_seen = col_addr; drain_seen = drain_sel;
        for (int cyc = 1; cyc < 400; cyc++) begin
            pen = prog_en | tun_en;
            if (pen && !prev) begin
                if (n_rises < 8) rise_at[n_rises] = cyc;
                n_rises++;
            end
            prev = pen;
            prog_cyc += int'(prog_en);
            tun_cyc  += int'(tun_en);
            if ((prog_en && tun_en) || (pen && !(dec_en && drain_sel))) inv_err++;
            if (cmd_ready) ready_err++;
            if (dec_en | drain_sel | prog_en | tun_en | meas_req) any_en = 1;
            if (meas_req && meas_cyc < 0) meas_cyc = cyc;
            if (meas_req && drain_sel) drain_in_meas++;
            if (rsp_valid) begin
                rsp_cyc  = cyc;
                rsp_stat = int'(rsp_status);
                break;
            end
            meas_ack = meas_req && (cyc - meas_cyc >= ack_delay);
            abort    = (cyc == abort_at);
            if (cyc == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                break;
            end
            step();
        end
        meas_ack = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        step(); step(); step();
        rst = 1'b0;
        check("reset_outs", all_outs(), 0);
        check("reset_ready", cmd_ready, 1);

        // Inject island 1, row 5, col 3, 3 pulses of 4 cycles, ack 2 cycles after meas_req
        run_cmd(2'd1, 6'd5, 6'd3, 2'b00, 8'd3, 4'd4, 2, -1, -1);
        check("inj_island_sel", isl_seen, 3'b010);
        check("inj_row", row_seen, 5);
        check("inj_col", col_seen, 3);
        check("inj_drain", drain_seen, 1);
        check("inj_rises", n_rises, 3);
        check("inj_rise0", rise_at[0], 9);
        check("inj_rise1", rise_at[1], 21);
        check("inj_rise2", rise_at[2], 33);
        check("inj_prog_cyc", prog_cyc, 12);
        check("inj_tun_cyc", tun_cyc, 0);
        check("inj_meas_cyc", meas_cyc, 45);
        check("inj_drain_meas", drain_in_meas, 0);
        check("inj_rsp_cyc", rsp_cyc, 48);
        check("inj_status", rsp_stat, 0);
        check("inj_invariant", inv_err, 0);
        check("inj_ready_busy", ready_err, 0);
        step();
        check("inj_ready_after", cmd_ready, 1);

        // Read with 7 pulses requested: no pulses, measure straight after settle, ack same cycle
        run_cmd(2'd2, 6'd63, 6'd0, 2'b10, 8'd7, 4'd4, 0, -1, -1);
        check("rd_island_sel", isl_seen, 3'b100);
        check("rd_drain", drain_seen, 0);
        check("rd_pulse_cyc", prog_cyc + tun_cyc, 0);
        check("rd_meas_cyc", meas_cyc, 9);
        check("rd_drain_meas", drain_in_meas, 0);
        check("rd_rsp_cyc", rsp_cyc, 10);
        check("rd_status", rsp_stat, 0);
        step();
        check("rd_ready_after", cmd_ready, 1);

        // Island index past the island count
        run_cmd(2'd3, 6'd1, 6'd1, 2'b00, 8'd2, 4'd2, 0, -1, -1);
        check("badisl_rsp_cyc", rsp_cyc, 1);
        check("badisl_status", rsp_stat, 2);
        check("badisl_any_en", any_en, 0);
        step();
        check("badisl_ready_after", cmd_ready, 1);

        // Reserved mode
        run_cmd(2'd0, 6'd1, 6'd1, 2'b11, 8'd2, 4'd2, 0, -1, -1);
        check("badmode_rsp_cyc", rsp_cyc, 1);
        check("badmode_status", rsp_stat, 2);
        check("badmode_any_en", any_en, 0);
        step();

        // Tunnel, 3 pulses of 4, abort during the second pulse (pulse covers cycles 21..24)
        run_cmd(2'd0, 6'd9, 6'd10, 2'b01, 8'd3, 4'd4, 0, 22, -1);
        check("abt_tun_cyc", tun_cyc, 6);
        check("abt_prog_cyc", prog_cyc, 0);
        check("abt_rises", n_rises, 2);
        check("abt_rsp_cyc", rsp_cyc, 23);
        check("abt_tun_now", tun_en, 0);
        check("abt_status", rsp_stat, 1);
        check("abt_meas", meas_cyc, -1);
        step();
        check("abt_ready_after", cmd_ready, 1);

        // Tunnel, W=0 treated as a single cycle
        run_cmd(2'd1, 6'd2, 6'd2, 2'b01, 8'd1, 4'd0, 1, -1, -1);
        check("w0_rises", n_rises, 1);
        check("w0_tun_cyc", tun_cyc, 1);
        check("w0_meas_cyc", meas_cyc, 18);
        check("w0_rsp_cyc", rsp_cyc, 20);
        check("w0_status", rsp_stat, 0);
        step();

        // Full-scale width must run all 15 cycles
        run_cmd(2'd0, 6'd4, 6'd4, 2'b00, 8'd1, 4'd15, 0, -1, -1);
        check("wmax_rise0", rise_at[0], 9);
        check("wmax_prog_cyc", prog_cyc, 15);
        check("wmax_meas_cyc", meas_cyc, 32);
        check("wmax_rsp_cyc", rsp_cyc, 33);
        step();

        // Reset during the first gap (cycles 13..20)
        run_cmd(2'd1, 6'd5, 6'd3, 2'b00, 8'd3, 4'd4, 0, -1, 15);
        check("rst_outs", all_outs(), 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_no_rsp", rsp_cyc, -1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_rsp_quiet", rsp_valid, 0);
        end
        run_cmd(2'd1, 6'd7, 6'd8, 2'b01, 8'd1, 4'd0, 1, -1, -1);
        check("post_rst_isl", isl_seen, 3'b010);
        check("post_rst_tun_cyc", tun_cyc, 1);
        check("post_rst_rsp_cyc", rsp_cyc, 20);
        check("post_rst_status", rsp_stat, 0);
        check("post_rst_invariant", inv_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
